// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for eight requesters sharing one 3x8 decoder.
// One grant at a time, bounded hold time, one idle cycle between owners.
module rr_arbiter_8 #(
    parameter int N_REQ    = 8,
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    output logic [N_REQ-1:0]  gnt,
    output logic [2:0]        gnt_idx,
    output logic              gnt_valid,
    output logic              preempt
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_r, state_nx_s;
    logic [N_REQ-1:0]   gnt_r, gnt_nx_s;
    logic [2:0]         gnt_idx_r, gnt_idx_nx_s;
    logic               gnt_valid_r, gnt_valid_nx_s;
    logic               preempt_r, preempt_nx_s;
    logic [2:0]         ptr_r, ptr_nx_s;
    logic [HOLD_W-1:0]  cnt_r, cnt_nx_s;
    logic               timeout_s;
    logic               held_s;

    // First set request at or above p, wrapping modulo 8.
    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] r, input logic [2:0] p);
        logic [2:0] cand;
        logic [2:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = p + 3'(i);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    assign timeout_s = (cnt_r == HOLD_W'(MAX_HOLD - 1));
    assign held_s    = req[gnt_idx_r];

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_nx_s     = state_r;
        gnt_idx_nx_s   = gnt_idx_r;
        gnt_valid_nx_s = gnt_valid_r;
        preempt_nx_s   = 1'b0;
        ptr_nx_s       = ptr_r;
        cnt_nx_s       = cnt_r;
        gnt_nx_s       = {N_REQ{1'b0}};
        case (state_r)
            IDLE: begin
                if (req != {N_REQ{1'b0}}) begin
                    state_nx_s     = GRANT;
                    gnt_idx_nx_s   = rr_pick(req, ptr_r);
                    gnt_valid_nx_s = 1'b1;
                    cnt_nx_s       = {HOLD_W{1'b0}};
                end else begin
                    gnt_valid_nx_s = 1'b0;
                end
            end
            GRANT: begin
                if (!held_s || timeout_s) begin
                    // A drop on the last allowed cycle is a release, not a preemption.
                    state_nx_s     = IDLE;
                    gnt_valid_nx_s = 1'b0;
                    ptr_nx_s       = gnt_idx_r + 3'd1;
                    cnt_nx_s       = {HOLD_W{1'b0}};
                    preempt_nx_s   = timeout_s && held_s;
                end else begin
                    gnt_valid_nx_s = 1'b1;
                    cnt_nx_s       = cnt_r + HOLD_W'(1);
                end
            end
            default: begin
                state_nx_s     = IDLE;
                gnt_valid_nx_s = 1'b0;
            end
        endcase
        if (gnt_valid_nx_s) begin
            gnt_nx_s = N_REQ'(1) << gnt_idx_nx_s;
        end else begin
            gnt_nx_s = {N_REQ{1'b0}};
        end
    end

    // State and output registers; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            gnt_r       <= {N_REQ{1'b0}};
            gnt_idx_r   <= 3'd0;
            gnt_valid_r <= 1'b0;
            preempt_r   <= 1'b0;
            ptr_r       <= 3'd0;
            cnt_r       <= {HOLD_W{1'b0}};
        end else begin
            state_r     <= state_nx_s;
            gnt_r       <= gnt_nx_s;
            gnt_idx_r   <= gnt_idx_nx_s;
            gnt_valid_r <= gnt_valid_nx_s;
            preempt_r   <= preempt_nx_s;
            ptr_r       <= ptr_nx_s;
            cnt_r       <= cnt_nx_s;
        end
    end

    assign gnt       = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign gnt_valid = gnt_valid_r;
    assign preempt   = preempt_r;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8: a vector table for reset, single grant and
// rotation, plus hand sequences for timeout, release-at-limit and mid-grant reset.
module tb_rr_arbiter_8;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       preempt;

    int total;
    int bad;

    typedef struct {
        string      name;
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       pre;
    } vec_t;

    vec_t vecs[$];

    rr_arbiter_8 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .preempt   (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input string n, input logic r, input logic [7:0] q,
                       input logic [7:0] g, input logic [2:0] i, input logic v, input logic p);
        vec_t t;
        t.name = n; t.rst = r; t.req = q; t.gnt = g; t.idx = i; t.valid = v; t.pre = p;
        vecs.push_back(t);
    endtask

    // Drive inputs, advance one clock, then compare outputs 1ns after the edge.
    task automatic step(input string n, input logic r, input logic [7:0] q,
                        input logic [7:0] g, input logic [2:0] i, input logic v, input logic p);
        rst = r;
        req = q;
        @(posedge clk);
        #1;
        total++;
        if ({gnt, gnt_idx, gnt_valid, preempt} !== {g, i, v, p}) begin
            bad++;
            $display("FAIL %s: got gnt=%h idx=%0d valid=%b preempt=%b, want gnt=%h idx=%0d valid=%b preempt=%b",
                     n, gnt, gnt_idx, gnt_valid, preempt, g, i, v, p);
        end
    endtask

    initial begin
        logic [7:0] b;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = 8'h00;

        add("reset0", 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
        add("reset1", 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0);
        add("single_g0", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        add("single_g1", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        add("single_g2", 1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0);
        add("single_rel", 1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
        add("single_idle", 1'b0, 8'h00, 8'h00, 3'd2, 1'b0, 1'b0);
        add("rot_reset", 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            b = 8'h01 << k;
            add($sformatf("rot%0d_a", k), 1'b0, 8'hFF, b, 3'(k), 1'b1, 1'b0);
            add($sformatf("rot%0d_b", k), 1'b0, 8'hFF, b, 3'(k), 1'b1, 1'b0);
            add($sformatf("rot%0d_gap", k), 1'b0, 8'hFF & ~b, 8'h00, 3'(k), 1'b0, 1'b0);
        end
        add("rot_wrap0", 1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);

        foreach (vecs[n]) begin
            step(vecs[n].name, vecs[n].rst, vecs[n].req, vecs[n].gnt,
                 vecs[n].idx, vecs[n].valid, vecs[n].pre);
        end

        // Timeout rotation between requesters 0 and 7.
        step("to_reset", 1'b1, 8'h81, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 15; c++) step($sformatf("to_hold0_%0d", c), 1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0);
        step("to_preempt0", 1'b0, 8'h81, 8'h00, 3'd0, 1'b0, 1'b1);
        for (int c = 0; c < 15; c++) step($sformatf("to_hold7_%0d", c), 1'b0, 8'h81, 8'h80, 3'd7, 1'b1, 1'b0);
        step("to_preempt7", 1'b0, 8'h81, 8'h00, 3'd7, 1'b0, 1'b1);
        step("to_wrap0", 1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 1'b0);

        // Release on the final allowed cycle is not a preemption.
        step("lim_reset", 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        for (int c = 0; c < 15; c++) step($sformatf("lim_hold3_%0d", c), 1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0);
        step("lim_release", 1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);
        step("lim_idle", 1'b0, 8'h00, 8'h00, 3'd3, 1'b0, 1'b0);

        // Reset during a grant to 5 clears the pointer left at 4.
        for (int c = 0; c < 5; c++) step($sformatf("mid_hold5_%0d", c), 1'b0, 8'h20, 8'h20, 3'd5, 1'b1, 1'b0);
        step("mid_reset", 1'b1, 8'h20, 8'h00, 3'd0, 1'b0, 1'b0);
        step("mid_after0", 1'b0, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
